// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC capture sequencer.
//   state_t      : measurement sequencer states
//   fine_width() : width of the population-count fine code for a tap count
//   FINE_LSB     : bit offset of the fine code inside the output word
//   coarse_lsb() : bit offset of the coarse timestamp inside the output word
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_SAMPLE,
    S_ENCODE,
    S_OUTPUT,
    S_HOLD
  } state_t;

  // A popcount of N taps ranges over 0..N, so it needs clog2(N+1) bits.
  function automatic int fine_width(input int tap_num);
    return $clog2(tap_num + 1);
  endfunction

  // Output word layout: fine code in the LSBs, coarse timestamp above it.
  localparam int FINE_LSB = 0;

  function automatic int coarse_lsb(input int tap_num);
    return FINE_LSB + fine_width(tap_num);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Registered population count of the latched thermometer word.
// Counting ones rather than searching for the first zero makes the code
// insensitive to bubbles in the delay-line snapshot.
//   clk, rst : clock and asynchronous active-high reset
//   en       : load the count register this cycle
//   taps     : TAP_NUM-bit thermometer snapshot
//   count    : FINE_W-bit registered number of ones in taps
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int TAP_NUM = 64,
  localparam int FINE_W = fine_width(TAP_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [TAP_NUM-1:0] taps,
  output logic [FINE_W-1:0]  count
);

  logic [FINE_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAP_NUM; i++) begin
      sum = sum + FINE_W'(taps[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= sum;
    end
  end

endmodule

// File: rtl/tdc_capture_seq.sv
// TDC measurement sequencer (initiator side of the clr/latch interface).
// Waits for a synchronized hit, raises clr so the latch controller freezes the
// delay line, reads back the thermometer taps, encodes them by popcount and
// emits {coarse timestamp, fine code} on a valid/ready stream. clr is then held
// low for a hold-off window so the next rising edge is seen cleanly.
//   clk, rst   : clock and asynchronous active-high reset
//   arm_en     : level, permits arming
//   hit_sync   : hit flag already synchronized to clk
//   tap_data   : latched thermometer snapshot, stable after the latch pulse
//   clr        : registered; its rising edge triggers the latch pulse
//   out_data   : {coarse, fine} measurement word
//   out_valid  : out_data valid
//   out_ready  : downstream accept
//   busy       : high outside IDLE and ARMED
//   drop_cnt   : saturating count of hits ignored while not ARMED
module tdc_capture_seq
  import tdc_pkg::*;
#(
  parameter int TAP_NUM = 64,
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 4,
  localparam int FINE_W = fine_width(TAP_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm_en,
  input  logic                    hit_sync,
  input  logic [TAP_NUM-1:0]      tap_data,
  output logic                    clr,
  output logic [CNT_W+FINE_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  localparam int HC_W = $clog2(HOLDOFF + 1);
  localparam int COARSE_LSB = coarse_lsb(TAP_NUM);

  state_t             state;
  state_t             state_nxt;
  logic [HC_W-1:0]    hold_cnt;
  logic [HC_W-1:0]    hold_nxt;
  logic [CNT_W-1:0]   coarse;
  logic [CNT_W-1:0]   ts_reg;
  logic [TAP_NUM-1:0] tap_reg;
  logic [FINE_W-1:0]  fine;

  // Next-state logic. HOLD lasts exactly HOLDOFF cycles; together with the
  // ARMED cycle that follows, clr is low for more than HOLDOFF cycles.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      S_IDLE:    if (arm_en) state_nxt = S_ARMED;
      S_ARMED: begin
        if (!arm_en)       state_nxt = S_IDLE;
        else if (hit_sync) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_SAMPLE;
      S_SAMPLE:  state_nxt = S_ENCODE;
      S_ENCODE:  state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        if (out_valid && out_ready) begin
          state_nxt = S_HOLD;
          hold_nxt  = HC_W'(HOLDOFF);
        end
      end
      S_HOLD: begin
        if (hold_cnt <= HC_W'(1)) begin
          hold_nxt  = '0;
          state_nxt = arm_en ? S_ARMED : S_IDLE;
        end else begin
          hold_nxt = hold_cnt - HC_W'(1);
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State and registered control outputs. clr is high exactly while the
  // sequencer is between the hit and the accepted output word, so it only
  // toggles on ARMED->CAPTURE and OUTPUT->HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      clr       <= 1'b0;
      out_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      clr       <= (state_nxt inside {S_CAPTURE, S_SAMPLE, S_ENCODE, S_OUTPUT});
      out_valid <= (state_nxt == S_OUTPUT);
      hold_cnt  <= hold_nxt;
    end
  end

  // Datapath: free-running coarse counter, timestamp at the hit, tap snapshot
  // one cycle after the latch pulse, and the dropped-hit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse   <= '0;
      ts_reg   <= '0;
      tap_reg  <= '0;
      drop_cnt <= '0;
    end else begin
      coarse <= coarse + CNT_W'(1);
      if (state == S_ARMED && state_nxt == S_CAPTURE) begin
        ts_reg <= coarse;
      end
      if (state == S_SAMPLE) begin
        tap_reg <= tap_data;
      end
      if (hit_sync && state != S_ARMED && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  tdc_popcount #(
    .TAP_NUM (TAP_NUM)
  ) u_popcount (
    .clk   (clk),
    .rst   (rst),
    .en    (state == S_ENCODE),
    .taps  (tap_reg),
    .count (fine)
  );

  always_comb begin
    out_data = '0;
    out_data[FINE_LSB +: FINE_W]  = fine;
    out_data[COARSE_LSB +: CNT_W] = ts_reg;
  end

  assign busy = !(state inside {S_IDLE, S_ARMED});

endmodule
